// File: rtl/face_timeout_timer.sv
// face_timeout_timer
// Tick timebase for the face-display FSM. While timer_enable is held high it
// emits a one-cycle timeout pulse every TICK_CYCLES clocks and counts the
// completed ticks in a saturating counter. Dropping timer_enable discards any
// partial tick and clears everything, so each enable starts a full first tick.
module face_timeout_timer #(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int CNT_W       = 26,
  parameter int SEC_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timer_enable,
  output logic             timeout,
  output logic [SEC_W-1:0] seconds,
  output logic             running
);

  // Last prescaler value of a tick, compared at full prescaler width.
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] pre;

  // Tick counter increment that holds at all-ones instead of wrapping.
  function automatic logic [SEC_W-1:0] sat_inc(input logic [SEC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Single FSM: prescaler, tick pulse, elapsed count and running flag are all
  // registered here; reset and abort both land in IDLE with everything clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      pre     <= '0;
      timeout <= 1'b0;
      seconds <= '0;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pre     <= '0;
          timeout <= 1'b0;
          seconds <= '0;
          running <= 1'b0;
          if (timer_enable) begin
            state   <= COUNT;
            running <= 1'b1;
          end
        end

        COUNT: begin
          if (!timer_enable) begin
            // Abort beats a coinciding tick: no pulse, count discarded.
            state   <= IDLE;
            pre     <= '0;
            timeout <= 1'b0;
            seconds <= '0;
            running <= 1'b0;
          end else if (pre == TICK_LAST) begin
            pre     <= '0;
            timeout <= 1'b1;
            seconds <= sat_inc(seconds);
          end else begin
            pre     <= pre + 1'b1;
            timeout <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          pre     <= '0;
          timeout <= 1'b0;
          seconds <= '0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_face_timeout_timer.sv
// Testbench for face_timeout_timer: directed scenarios followed by random
// enable/reset traffic, checked cycle by cycle through a scoreboard queue fed
// by an elapsed-time reference model.
module tb_face_timeout_timer;

  localparam int TICK  = 4;
  localparam int CNT_W = 3;
  localparam int SEC_W = 2;
  localparam int SMAX  = (1 << SEC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             timer_enable = 1'b0;
  logic             timeout;
  logic [SEC_W-1:0] seconds;
  logic             running;

  face_timeout_timer #(
    .TICK_CYCLES(TICK),
    .CNT_W      (CNT_W),
    .SEC_W      (SEC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .timer_enable(timer_enable),
    .timeout     (timeout),
    .seconds     (seconds),
    .running     (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             t;
    logic [SEC_W-1:0] s;
    logic             r;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   done   = 0;

  // Reference model: whether a run is active and how many clocks have passed
  // since the run's start edge. Outputs follow from plain arithmetic on that.
  bit m_active = 0;
  int m_age    = 0;

  task automatic model_edge(input logic r, input logic e);
    if (!r) begin
      m_active = 0;
      m_age    = 0;
    end else if (!m_active) begin
      if (e) begin
        m_active = 1;
        m_age    = 0;
      end
    end else if (!e) begin
      m_active = 0;
      m_age    = 0;
    end else begin
      m_age++;
    end
  endtask

  function automatic exp_t model_out();
    exp_t x;
    int   secs;
    secs  = m_age / TICK;
    if (secs > SMAX) secs = SMAX;
    x.t   = m_active && (m_age > 0) && (m_age % TICK == 0);
    x.s   = m_active ? SEC_W'(secs) : '0;
    x.r   = m_active;
    x.cyc = cycle;
    return x;
  endfunction

  // Apply inputs, clock one edge, then record what the DUT must show.
  task automatic step(input logic r, input logic e);
    rst          = r;
    timer_enable = e;
    @(posedge clk);
    cycle++;
    model_edge(r, e);
    q.push_back(model_out());
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  // Monitor: every falling edge compare the DUT outputs with the oldest entry.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if (timeout !== x.t) begin
        errors++;
        $display("FAIL timeout cycle %0d: got %b expected %b", x.cyc, timeout, x.t);
      end
      checks++;
      if (seconds !== x.s) begin
        errors++;
        $display("FAIL seconds cycle %0d: got %0d expected %0d", x.cyc, seconds, x.s);
      end
      checks++;
      if (running !== x.r) begin
        errors++;
        $display("FAIL running cycle %0d: got %b expected %b", x.cyc, running, x.r);
      end
    end
  end

  initial begin
    logic r;
    logic e;
    // Reset held with enable high.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    idle(2);

    // Basic run through saturation.
    for (int i = 0; i < 19; i++) step(1'b1, 1'b1);
    idle(3);

    // Abort sampled exactly on the first tick edge.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    idle(4);

    // Abort mid tick and restart.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
    idle(3);

    // Reset in the middle of a run with enable kept high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1);
    idle(2);

    // Random traffic: long enable runs, occasional aborts and resets.
    e = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) e = ~e;
      r = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      step(r, e);
    end
    idle(2);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #500000;
    if (!done) begin
      $display("FAIL timeout_watchdog: got cycle %0d expected completion", cycle);
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
    end
  end

endmodule

// File: doc/face_timeout_timer.md
# face_timeout_timer

Timebase responder for the face-display FSM (SubCreateFace). While `timer_enable` is held high it emits a one-cycle `timeout` pulse every `TICK_CYCLES` clocks (1 s at 50 MHz by default) and tracks elapsed whole ticks. Dropping `timer_enable` aborts and clears it, so every face display starts from a fresh, full-length first tick. The block sits between the system clock domain and the face FSM's `timer_enable`/`timeout` handshake.

## Interface
- `TICK_CYCLES`, 50_000_000, clocks per `timeout` pulse; must be ≥ 2.
- `CNT_W`, 26, prescaler width; must satisfy 2^CNT_W ≥ `TICK_CYCLES`.
- `SEC_W`, 4, width of the elapsed-tick counter.

- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-low (rst == 0 resets on the next posedge).
- `timer_enable`  in  1  level request from the face FSM; high = run, low = abort/idle.
- `timeout`  out  1  registered one-cycle pulse at each completed tick.
- `seconds`  out  SEC_W  elapsed completed ticks since enable; saturating.
- `running`  out  1  high while in COUNT.

## Operation
- Two-state FSM: IDLE, COUNT. Internal prescaler `pre[CNT_W-1:0]`.
- Reset (`rst`==0 at a posedge) puts the block in IDLE with `pre`=0, `timeout`=0, `seconds`=0, `running`=0. Reset overrides every other condition.
- **IDLE:**
  - Holds `pre`=0, `timeout`=0, `seconds`=0, `running`=0.
  - If `timer_enable`==1 is sampled: next state COUNT, `pre`<=0, `running`<=1.
- **COUNT, `timer_enable`==1:**
  - If `pre`==`TICK_CYCLES`-1: `pre`<=0, `timeout`<=1, and `seconds`<=`seconds`+1. When `seconds` is already 2^SEC_W-1 it holds that value.
  - Otherwise: `pre`<=`pre`+1 and `timeout`<=0.
- **COUNT, `timer_enable`==0:**
  - Next state IDLE, with `pre`, `seconds`, `timeout` and `running` all cleared.
  - A partially counted tick is discarded and no `timeout` is issued.
- `timeout` is never high in two consecutive cycles, since `TICK_CYCLES` ≥ 2.
- Arithmetic: `pre` compare uses `TICK_CYCLES`-1 at full CNT_W width. `seconds` is unsigned and never wraps.

## Timing
- Let E0 be the posedge at which `timer_enable`==1 is first sampled in IDLE. `running` is high from E0.
- The first `timeout` is high from posedge E0+`TICK_CYCLES` to E0+`TICK_CYCLES`+1.
- Subsequent pulses follow every `TICK_CYCLES` clocks while enable stays high.
- `seconds` increments on the same edge that raises `timeout`.
- Simultaneous tick and abort: if `timer_enable`==0 at the edge where `pre`==`TICK_CYCLES`-1, the abort wins. No pulse is issued and `seconds` stays 0 afterwards.
- Re-enable after abort:
  - At least one cycle is spent in IDLE.
  - The next E0 restarts the full first-tick latency; there is no partial carry-over.
- Reset mid-COUNT: outputs are cleared on that edge. If `timer_enable` is still 1 when `rst` returns high, the block re-enters COUNT on the first non-reset edge, and that edge becomes the new E0.
- Consumer contract: the face FSM holds `timer_enable` high for its whole Timer state. It counts two `timeout` pulses, then drops enable, which returns this block to IDLE.

## Test plan
All scenarios use `TICK_CYCLES`=4 and `SEC_W`=2.

- **Reset:** hold `rst`=0 for 3 cycles with `timer_enable`=1 → `timeout`=0, `seconds`=0, `running`=0 throughout.
- **Basic run:** `timer_enable` goes to 1 at E0 and is held → `running`=1 from E0. `timeout` pulses at E0+4, E0+8 and E0+12, each exactly one cycle wide. `seconds` reads 1, 2, 3 after those edges.
- **Saturation:** continue the basic run to E0+16 → `timeout` still pulses, `seconds` stays 3.
- **Abort at tick edge:** enable at E0, drop `timer_enable` so it is sampled 0 at E0+4 → no `timeout` pulse at any point, `seconds`=0, `running`=0 after E0+4.
- **Abort and restart:** enable at E0, drop at E0+2, re-raise so it is sampled at E0+4 (new E0') → first `timeout` at E0'+4, not earlier.
- **Reset mid-count:** enable at E0, `rst`=0 sampled at E0+3 then released, `timer_enable` held 1 → all outputs 0 at E0+3, re-entry at E0+4, first `timeout` at E0+8.
